// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and its instruction store.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        FULL = 2'd3
    } loader_state_t;

    localparam int MACH_W = 9;

    // True in the states where the loader is still taking words from the source.
    function automatic logic state_accepting(input loader_state_t s);
        logic open_s;
        case (s)
            IDLE:    open_s = 1'b1;
            LOAD:    open_s = 1'b1;
            DONE:    open_s = 1'b0;
            FULL:    open_s = 1'b0;
            default: open_s = 1'b0;
        endcase
        return open_s;
    endfunction

endpackage

// File: rtl/instr_RAM.sv
// Writable instruction store: one synchronous write port, one combinational
// read port that behaves exactly like the instruction ROM on the fetch side.
module instr_RAM
    import prog_loader_pkg::*;
#(
    parameter int D = 12,
    parameter int W = MACH_W
) (
    input  logic         Clk,
    input  logic         we,
    input  logic [D-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [D-1:0] prog_ctr,
    output logic [W-1:0] mach_code
);

    logic [W-1:0] mem_q [0:(2**D)-1];

    // Write port: one word per cycle at the loader's current fill address.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign mach_code = mem_q[prog_ctr];

endmodule

// File: rtl/prog_loader.sv
// Streams machine-code words into the instruction store from address 0 and
// exposes the loaded program to the core's fetch once loading completes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int D = 12,
    parameter int W = MACH_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         reload,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic [D-1:0] prog_ctr,
    output logic [W-1:0] mach_code,
    output logic         load_done,
    output logic         load_err,
    output logic [D:0]   word_count
);

    localparam logic [D:0] LAST_ADDR = {1'b0, {D{1'b1}}};
    localparam logic [D:0] COUNT_ONE = {{D{1'b0}}, 1'b1};

    loader_state_t state_q, state_d;
    logic [D:0]    count_q, count_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          in_ready_s;
    logic          accept_s;
    logic          we_s;
    logic [W-1:0]  ram_code_s;

    // Handshake: open only in IDLE/LOAD, and never in a reload cycle.
    always_comb begin
        in_ready_s = state_accepting(state_q) && !reload;
        accept_s   = in_valid && in_ready_s;
        we_s       = accept_s && !Reset;
    end

    // Next-state, fill counter and completion/error flags.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;
        if (reload) begin
            state_d = IDLE;
            count_d = {(D+1){1'b0}};
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept_s) begin
            count_d = count_q + COUNT_ONE;
            if (in_last) begin
                // in_last wins over a full memory: an exact fill is a good load
                state_d = DONE;
                done_d  = 1'b1;
            end else if (count_q == LAST_ADDR) begin
                state_d = FULL;
                err_d   = 1'b1;
            end else begin
                state_d = LOAD;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State register; Reset overrides reload and everything else.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= {(D+1){1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    instr_RAM #(
        .D (D),
        .W (W)
    ) u_ram (
        .Clk       (Clk),
        .we        (we_s),
        .wr_addr   (count_q[D-1:0]),
        .wr_data   (in_data),
        .prog_ctr  (prog_ctr),
        .mach_code (ram_code_s)
    );

    assign in_ready   = in_ready_s;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign word_count = count_q;
    // Hold the core on the all-zero encoding until the program is complete.
    assign mach_code  = done_q ? ram_code_s : {W{1'b0}};

endmodule

// File: doc/prog_loader.md
# prog_loader

Writer side of the instruction store: accepts a stream of 9-bit machine-code words over a valid/ready handshake, writes them sequentially from address 0 into a writable instruction memory, and signals completion to the core. Once loaded, it serves the core's fetch exactly as the instruction ROM does: the core's `prog_ctr` goes in and the combinational `mach_code` comes out. It sits between the testbench or host program source and the core's fetch stage, and replaces preloading via a file.

## Interface
- `D`, 12: address width; depth is 2**D words.
- `W`, 9: machine-code word width.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `reload` input 1: restart the load; has priority in every state.
- `in_valid` input 1: `in_data` and `in_last` are valid.
- `in_ready` output 1: the loader can accept a word this cycle.
- `in_data` input W: machine-code word.
- `in_last` input 1: the current word is the final word of the program.
- `prog_ctr` input D: fetch address from the core.
- `mach_code` output W: instruction at `prog_ctr`.
- `load_done` output 1: the program is loaded and fetch is valid.
- `load_err` output 1: the memory filled without `in_last`.
- `word_count` output D+1: number of words written in the current load.

## Operation
- **States** (held in a register):
  - IDLE: after reset or reload.
  - LOAD: at least one word has been accepted.
  - DONE: the last word has been accepted.
  - FULL: error state.
- **Accept rule:** a word is accepted when `in_valid && in_ready`.
- **`in_ready`:** combinational. `in_ready = (state==IDLE || state==LOAD) && !reload`.
- **Write on accept:**
  - `mem[word_count[D-1:0]] <= in_data`.
  - `word_count <= word_count+1`.
- **Transitions on accept:**
  - `in_last=1` → DONE.
  - Otherwise, if `word_count` was 2**D-1 → FULL.
  - Otherwise, IDLE or LOAD → LOAD.
- **No accept:** the state is held. IDLE stays IDLE. LOAD stalls indefinitely.
- **DONE:**
  - `load_done=1`.
  - `in_ready=0`; later words are not accepted.
  - `word_count` is frozen.
- **FULL:**
  - `load_err=1`.
  - `in_ready=0`.
  - `word_count=2**D`.
  - `load_done=0`.
- **`reload`:** when high in any state, the next state is IDLE with `word_count=0` and both flags cleared. The memory contents are not cleared. While `reload=1`, `in_ready=0`, so a word is never written in a reload cycle.
- **Fetch:**
  - `mach_code = load_done ? mem[prog_ctr] : '0`. The all-zero word holds the core on a harmless encoding during loading.
  - The read is combinational.
- **Boundaries:**
  - Last word at address 2**D-1 with `in_last=1` → DONE, not FULL. `word_count=2**D`.
  - A single-word program (the first accept has `in_last`) goes IDLE→DONE directly.
  - An empty program is not supported. DONE requires at least one accepted word.
- **`Reset`:** same effect as `reload`, and additionally has priority over `reload`. Memory is not initialised.

## Timing
- **After reset:**
  - state=IDLE, `word_count=0`, `load_done=0`, `load_err=0`.
  - `in_ready=1` (if `reload=0`).
  - `mach_code=0`.
- **Throughput:** one word per cycle while `in_valid` is held high.
- **Write latency:** a word accepted at edge N is stored by edge N. It is readable through `mach_code` from cycle N+1 onward, provided `load_done` is set.
- **Flag timing:**
  - `load_done` rises in the cycle after the edge that accepts `in_last`.
  - `load_err` rises in the cycle after the edge that accepts word 2**D-1 without `in_last`.
- **Source rules:**
  - The source may change `in_data` and `in_last` freely while `in_ready=0`.
  - The loader never requires `in_valid` to be held.
- **Combinational path:** `prog_ctr`→`mach_code`, with no added latency versus the ROM.

## Structure
- Package `prog_loader_pkg`:
  - State enum `loader_state_t` {IDLE, LOAD, DONE, FULL}.
  - Constant `MACH_W=9`.
- Sub-module `instr_RAM #(D,W)`:
  - One synchronous write port (`we`, `wr_addr`, `wr_data`).
  - One combinational read port (`prog_ctr` → `mach_code`).
  - Same read behaviour as the ROM, so the core-side port list is unchanged.
- The top holds the FSM, the counter, the handshake logic and the `mach_code` gating.

## Test plan
- **Basic load:** reset, then stream 8 words 9'h07E, 9'h066, …, 9'h1DE back-to-back, with `in_last` on the 8th. Required: `load_done`=1 one cycle after the 8th accept, `word_count`=8, and `prog_ctr`=0..7 returns the same words. During the load, `mach_code`=0.
- **Bubbles:** toggle `in_valid` every other cycle over 5 words. Required: exactly 5 writes, addresses 0..4 contiguous, `word_count`=5.
- **Post-done input:** while in DONE, drive `in_valid`=1 with data 9'h1FF. Required: `in_ready`=0, memory unchanged, `word_count` unchanged.
- **Overflow:** with D=3, stream 8 words with no `in_last`. Required: FULL, `load_err`=1, `word_count`=8, `in_ready`=0. Then pulse `reload`. Required: IDLE, `load_err`=0, `word_count`=0.
- **Exact fill:** with D=3, 8 words with `in_last` on the 8th. Required: DONE, `load_err`=0, `word_count`=8.
- **Reload mid-load:** assert `reload` in the same cycle as `in_valid` on word 3. Required: `in_ready`=0, no write, next state IDLE. A subsequent 2-word load writes addresses 0..1.
